// File: rtl/dm_pkg.sv
// Shared constants for the data-memory arbiter: FSM encoding and memory geometry.
package dm_pkg;

  localparam int unsigned DM_WORD_BYTES = 4;
  localparam int unsigned DM_MEM_BYTES  = 128;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StAccess  = 2'd1;
  localparam logic [1:0] StCapture = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  function automatic logic dm_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational winner selection between the two request ports.
// DM_ARB_RR_EN selects round-robin on contention; otherwise port 0 has fixed priority.
module dm_arb_pick (
  input  logic req0_i,
  input  logic req1_i,
  input  logic ptr_i,
  output logic gnt_idx_o,
  output logic gnt_valid_o
);

  assign gnt_valid_o = req0_i | req1_i;

`ifdef DM_ARB_RR_EN
  // On contention the port that was not granted last wins.
  assign gnt_idx_o = (req0_i & req1_i) ? ~ptr_i : req1_i;
`else
  logic unused_ptr;
  assign unused_ptr = ptr_i;
  assign gnt_idx_o  = req1_i & ~req0_i;
`endif

endmodule

// File: rtl/dm_arbiter.sv
// Two-port word access controller for the big-endian data memory.
// Define DM_ARB_RR_EN for round-robin arbitration; default is fixed priority to port 0.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DM_MEM_BYTES,
  parameter int unsigned AW        = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [31:0]   wdata0,
  input  logic [31:0]   wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          err0,
  output logic          err1,
  output logic [31:0]   rdata,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [31:0]   mem_rdata
);

  localparam logic [AW-1:0] LastWord = AW'(MEM_BYTES - DM_WORD_BYTES);

  logic [1:0]    state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;

  logic          last_gnt;
  logic          pick_idx, pick_valid;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;
  logic          sel_we, sel_ok;

`ifdef DM_ARB_RR_EN
  logic last_q, last_d;
  assign last_gnt = last_q;
`else
  assign last_gnt = 1'b1;
`endif

  dm_arb_pick u_pick (
    .req0_i      (req0),
    .req1_i      (req1),
    .ptr_i       (last_gnt),
    .gnt_idx_o   (pick_idx),
    .gnt_valid_o (pick_valid)
  );

  assign sel_addr  = pick_idx ? addr1  : addr0;
  assign sel_wdata = pick_idx ? wdata1 : wdata0;
  assign sel_we    = pick_idx ? we1    : we0;
  assign sel_ok    = dm_word_aligned(sel_addr[1:0]) && (sel_addr <= LastWord);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err0_d      = 1'b0;
    err1_d      = 1'b0;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    // Strobes default low so they can never stay high past the ACCESS cycle.
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
`ifdef DM_ARB_RR_EN
    last_d      = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_d = pick_idx;
`ifdef DM_ARB_RR_EN
          last_d = pick_idx;
`endif
          if (sel_ok) begin
            we_d        = sel_we;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
            mem_write_d = sel_we;
            mem_read_d  = ~sel_we;
            state_d     = StAccess;
          end else begin
            ack0_d  = ~pick_idx;
            ack1_d  = pick_idx;
            err0_d  = ~pick_idx;
            err1_d  = pick_idx;
            state_d = StDone;
          end
        end
      end
      StAccess: state_d = StCapture;
      StCapture: begin
        if (!we_q) begin
          rdata_d = mem_rdata;
        end
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

`ifdef DM_ARB_RR_EN
  // Reset to port 1 so that port 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port access controller for the 128-byte big-endian data memory. Arbitrates word accesses between the CPU load/store path (port 0) and a debug/DMA loader (port 1), checks alignment and range, and sequences the memory's control lines. Write commits on the memory's falling edge and read data is registered on its rising edge. Sits between the requesters and the data memory; the memory is the only downstream consumer.

## Interface
Parameters:
- `MEM_BYTES`, 128: memory size in bytes; must be a multiple of 4.
- `AW`, 32: address width.

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `req0`, `req1`  in  1  access request, port 0 / port 1; level, held until ack.
- `we0`, `we1`  in  1  1 = write, 0 = read; stable while req high.
- `addr0`, `addr1`  in  AW  byte address.
- `wdata0`, `wdata1`  in  32  write data.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `err0`, `err1`  out  1  valid with ack; 1 = rejected access.
- `rdata`  out  32  read result, valid with ack of a read.
- `mem_addr`  out  AW  to memory address.
- `mem_wdata`  out  32  to memory write data.
- `mem_read`, `mem_write`  out  1  to memory strobes.
- `mem_rdata`  in  32  from memory read data.

## Operation
- All outputs are registered.
- Reset values: every output 0; state IDLE; last-grant pointer = 1, so port 0 wins first.
- FSM states: IDLE, ACCESS, CAPTURE, DONE.
- **IDLE:**
  - Samples `req0`/`req1` and picks a winner.
  - Checks the winner's address:
    - Legal (`addr[1:0]==0` and `addr <= MEM_BYTES-4`): latch addr/wdata/we, drive `mem_addr`, `mem_wdata`, and `mem_write=we` / `mem_read=!we`, then go to ACCESS.
    - Illegal: go straight to DONE with err set; no memory strobe.
- **ACCESS:** one cycle.
  - A write commits at this cycle's falling edge.
  - A read address is sampled by the memory at the closing rising edge.
  - Then go to CAPTURE.
- **CAPTURE:**
  - Deassert `mem_read`/`mem_write`.
  - On a read, latch `mem_rdata` into `rdata` at the closing edge.
  - `rdata` is unchanged on a write.
  - Then go to DONE.
- **DONE:**
  - `ack` of the granted port = 1 for exactly this cycle; `err` is valid.
  - Requests are not sampled; the requester drops or changes `req` here.
  - Then go to IDLE.
- **Simultaneous requests:** resolved by the arbitration policy (see Configuration). The loser keeps `req` high and is served next.
- **Request dropped mid-access:** the access still completes and ack is still pulsed.
- **Reset mid-operation:**
  - Strobes clear immediately.
  - A write whose falling edge has not yet occurred is suppressed.
  - FSM returns to IDLE.

## Timing
- req sampled at edge T0 → mem strobes high T0..T1 → CAPTURE T1..T2 → ack high T2..T3.
- Legal access: ack in the third cycle after sampling; throughput one access per 4 cycles.
- Illegal access: ack in the cycle after sampling (T0..T1); throughput one per 2 cycles.
- `rdata` is valid from T2 and holds until the next read completes.
- Strobes are never high for more than one cycle, and never both high together.

## Configuration
- `DM_ARB_RR_EN` defined:
  - Round-robin arbitration. On contention, the port not granted last wins.
  - The pointer updates on every grant, including error grants.
- `DM_ARB_RR_EN` undefined:
  - Fixed priority; port 0 always wins contention.
  - Pointer logic is removed; port 1 can starve by design.

## Structure
- Shared package `dm_pkg`:
  - FSM state encoding (2-bit localparams).
  - `DM_WORD_BYTES = 4`.
  - Default `MEM_BYTES = 128`.
- One natural sub-module: `dm_arb_pick`, the combinational winner selection. Inputs: two reqs and the pointer. Outputs: grant index and valid. This isolates the `DM_ARB_RR_EN` variant.

## Test plan
- **Reset:** hold `rst_n=0` with `req0=1` → all outputs 0, no strobe; release → first grant to port 0.
- **Port 0 round trip:** write 0xDEADBEEF to 0x10, then read 0x10 → `mem_write` pulses one cycle; ack0 is 3 cycles after sampling; `rdata`=0xDEADBEEF, `err0`=0.
- **Contention, RR enabled:** req0 and req1 both read and held high for 4 accesses → grants alternate 0,1,0,1. Without `DM_ARB_RR_EN`, grants are 0,0,0,0.
- **Rejected accesses:** addr 0x13 and addr 0x7D (both illegal) → ack+err in the next cycle, `mem_read`/`mem_write` never asserted, `rdata` unchanged.
- **Reset mid-access:** assert `rst_n=0` during the ACCESS cycle of a write to 0x20, before the falling edge → a later read of 0x20 returns the old value.
- **Boundary:** write and read at 0x7C → succeeds with `err`=0.
